sys_bus_arbiter: RTL and testbench
==================================

Name: sys_bus_arbiter

Overview:
Two-requester arbiter and sequencer for the shared 64-bit system bus (addr/wdata/sel/wen/ren/rdata/err/ack) behind the AXI slave bridges. Grants the bus to one requester at a time with round-robin fairness, holds the access until the target acks, and returns ack, err and rdata to the granted requester. A watchdog completes any access with an error if the target never acks.

Parameters:
AW, 32, address width
DW, 64, data width
SW, 8, byte-select width (DW/8)
TIMEOUT, 16, maximum cycles in ACCESS before forced error completion (>=2)

Ports:
axi_clk_i  in  1  clock
axi_rst_i  in  1  synchronous reset, active-high
m0_addr_i  in  AW  requester 0 address
m0_wdata_i  in  DW  requester 0 write data
m0_sel_i  in  SW  requester 0 byte selects
m0_wen_i  in  1  requester 0 write request (level, held until ack)
m0_ren_i  in  1  requester 0 read request (level, held until ack)
m0_rdata_o  out  DW  read data to requester 0, valid with m0_ack_o
m0_err_o  out  1  error to requester 0, valid with m0_ack_o
m0_ack_o  out  1  one-cycle completion pulse to requester 0
m1_* (addr_i, wdata_i, sel_i, wen_i, ren_i, rdata_o, err_o, ack_o)  as m0_*, for requester 1
sys_addr_o  out  AW  bus address
sys_wdata_o  out  DW  bus write data
sys_sel_o  out  SW  bus byte selects
sys_wen_o  out  1  bus write strobe
sys_ren_o  out  1  bus read strobe
sys_rdata_i  in  DW  bus read data
sys_err_i  in  1  bus error, valid with sys_ack_i
sys_ack_i  in  1  bus completion
grant_o  out  2  one-hot current owner, 0 when idle
busy_o  out  1  high in ACCESS or RELEASE

Behaviour:
- Single clock domain, synchronous active-high reset; all outputs are registered.
- Reset values: all sys_* outputs 0, all m*_ack/err/rdata 0, grant_o 0, busy_o 0, state IDLE, timeout counter 0, round-robin pointer set so m0 wins the first tie.
- req_n = mN_wen_i | mN_ren_i. If wen and ren are both high, the access is a write and ren is ignored.
- IDLE: no request -> stay. One request -> grant it. Both -> grant the requester not served last, then update the pointer. On the grant edge, capture that requester's addr/wdata/sel/wen/ren into the sys_* output registers, set grant_o and busy_o, clear the counter, and go to ACCESS.
- ACCESS: sys_wen_o/sys_ren_o held high with frozen addr/data/sel. The counter increments each cycle.
  - sys_ack_i=1: drop sys strobes; capture sys_rdata_i (reads only, else 0) and sys_err_i into the granted mN_rdata_o/mN_err_o; pulse mN_ack_o; go to RELEASE.
  - Counter = TIMEOUT-1 with no ack: same exit, but mN_err_o=1 and mN_rdata_o=0.
- RELEASE, exactly one cycle:
  - mN_ack_o high and strobes low.
  - sys_ack_i is ignored, so a late or stale ack is discarded.
  - Requester inputs are ignored.
  - Next state is IDLE, with grant_o=0 and busy_o=0 on that edge.
- Requesters deassert wen/ren on the edge where they sample ack, so their request is low in the following IDLE cycle.
- Latency: request seen in IDLE at cycle c; strobe on bus at c+1. With a one-cycle target (ack at c+2), mN_ack_o is high at c+3. The minimum back-to-back period is 4 cycles per access.
- Non-granted requester outputs stay 0. rdata/err hold their value until the next completion to that requester.
- An ack from the bus while in IDLE is ignored.
- Reset mid-access returns to IDLE immediately with all outputs 0. No ack is produced for the aborted access.

Decomposition:
- Shared package sys_bus_pkg: state enum (IDLE, ACCESS, RELEASE), default AW/DW/SW constants, and a packed request struct (addr, wdata, sel, wen, ren).
- One sub-module, rr_arbiter_2: two-way round-robin grant with pointer update on grant; combinational grant plus a registered pointer.

Test Plan:
- Reset: hold axi_rst_i 3 cycles while m0_ren_i=1 -> all outputs 0. After release, the m0 read is granted first (grant_o=2'b01).
- Single read: memory[0x1000>>3]=64'h0123456789ABCDEF; m0 reads 0x1000 -> sys_ren_o at c+1, m0_ack_o=1 at c+3 with that rdata, m0_err_o=0.
- Write then read: m1 writes 64'hDEADBEEF12345678 to 0x2000 with sel=8'h0F, then m0 reads 0x2000 -> rdata 64'h0000000012345678.
- Contention: m0 and m1 both request continuously for 4 accesses each -> grants alternate 01,10,01,10... and no requester is served twice in a row.
- Timeout: target never acks m1 read -> m1_ack_o=1 with m1_err_o=1 and rdata=0 exactly TIMEOUT cycles after entering ACCESS. A late sys_ack_i in RELEASE is discarded.
- Error and mid-access reset: target returns sys_err_i=1 with ack -> m0_err_o=1. Asserting axi_rst_i during ACCESS -> next cycle IDLE, sys strobes 0, no ack pulse.

Source files
------------

// File: rtl/sys_bus_pkg.sv
// Shared types and default widths for the system bus arbiter slice.
package sys_bus_pkg;

  localparam int unsigned SYS_AW = 32;
  localparam int unsigned SYS_DW = 64;
  localparam int unsigned SYS_SW = SYS_DW / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  typedef struct packed {
    logic [SYS_AW-1:0] addr;
    logic [SYS_DW-1:0] wdata;
    logic [SYS_SW-1:0] sel;
    logic              wen;
    logic              ren;
  } sys_req_t;

endpackage

// File: rtl/sys_bus_arbiter_rr.sv
// Two-way round-robin grant: combinational grant, registered last-served pointer.
module rr_arbiter_2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
    last_d = last_q;
    if (advance_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1];
    end
  end

  // Reset as if requester 1 was served last so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Two-requester system bus arbiter/sequencer with round-robin grant and ack watchdog.
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int unsigned AW      = SYS_AW,
  parameter int unsigned DW      = SYS_DW,
  parameter int unsigned SW      = SYS_SW,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          axi_clk_i,
  input  logic          axi_rst_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  input  logic [SW-1:0] m0_sel_i,
  input  logic          m0_wen_i,
  input  logic          m0_ren_i,
  output logic [DW-1:0] m0_rdata_o,
  output logic          m0_err_o,
  output logic          m0_ack_o,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic [SW-1:0] m1_sel_i,
  input  logic          m1_wen_i,
  input  logic          m1_ren_i,
  output logic [DW-1:0] m1_rdata_o,
  output logic          m1_err_o,
  output logic          m1_ack_o,
  output logic [AW-1:0] sys_addr_o,
  output logic [DW-1:0] sys_wdata_o,
  output logic [SW-1:0] sys_sel_o,
  output logic          sys_wen_o,
  output logic          sys_ren_o,
  input  logic [DW-1:0] sys_rdata_i,
  input  logic          sys_err_i,
  input  logic          sys_ack_i,
  output logic [1:0]    grant_o,
  output logic          busy_o
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] sys_addr_q, sys_addr_d;
  logic [DW-1:0] sys_wdata_q, sys_wdata_d;
  logic [SW-1:0] sys_sel_q, sys_sel_d;
  logic          sys_wen_q, sys_wen_d;
  logic          sys_ren_q, sys_ren_d;
  logic [1:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic [1:0]    req;
  logic [1:0]    gnt;
  sys_req_t      sel_req;
  logic          done;
  logic          done_err;
  logic [DW-1:0] done_rdata;

  assign req = {m1_wen_i | m1_ren_i, m0_wen_i | m0_ren_i};

  rr_arbiter_2 u_rr (
    .clk_i     (axi_clk_i),
    .rst_i     (axi_rst_i),
    .req_i     (req),
    .advance_i (state_q == IDLE),
    .gnt_o     (gnt)
  );

  always_comb begin
    if (gnt[1]) begin
      sel_req = '{addr: m1_addr_i, wdata: m1_wdata_i, sel: m1_sel_i,
                  wen: m1_wen_i, ren: m1_ren_i};
    end else begin
      sel_req = '{addr: m0_addr_i, wdata: m0_wdata_i, sel: m0_sel_i,
                  wen: m0_wen_i, ren: m0_ren_i};
    end
    sel_req.ren = sel_req.ren & ~sel_req.wen;
  end

  // A real ack wins over the watchdog on the final count.
  assign done       = sys_ack_i || (cnt_q == CNT_LAST);
  assign done_err   = sys_ack_i ? sys_err_i : 1'b1;
  assign done_rdata = (sys_ack_i && sys_ren_q) ? sys_rdata_i : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sys_addr_d  = sys_addr_q;
    sys_wdata_d = sys_wdata_q;
    sys_sel_d   = sys_sel_q;
    sys_wen_d   = sys_wen_q;
    sys_ren_d   = sys_ren_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    ack_d       = ack_q;
    err_d       = err_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          sys_addr_d  = sel_req.addr;
          sys_wdata_d = sel_req.wdata;
          sys_sel_d   = sel_req.sel;
          sys_wen_d   = sel_req.wen;
          sys_ren_d   = sel_req.ren;
          grant_d     = gnt;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (done) begin
          sys_wen_d = 1'b0;
          sys_ren_d = 1'b0;
          ack_d     = grant_q;
          if (grant_q[0]) begin
            err_d[0] = done_err;
            rdata0_d = done_rdata;
          end
          if (grant_q[1]) begin
            err_d[1] = done_err;
            rdata1_d = done_rdata;
          end
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        ack_d   = '0;
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk_i) begin
    if (axi_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sys_addr_q  <= '0;
      sys_wdata_q <= '0;
      sys_sel_q   <= '0;
      sys_wen_q   <= 1'b0;
      sys_ren_q   <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sys_addr_q  <= sys_addr_d;
      sys_wdata_q <= sys_wdata_d;
      sys_sel_q   <= sys_sel_d;
      sys_wen_q   <= sys_wen_d;
      sys_ren_q   <= sys_ren_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign sys_addr_o  = sys_addr_q;
  assign sys_wdata_o = sys_wdata_q;
  assign sys_sel_o   = sys_sel_q;
  assign sys_wen_o   = sys_wen_q;
  assign sys_ren_o   = sys_ren_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign m0_ack_o    = ack_q[0];
  assign m1_ack_o    = ack_q[1];
  assign m0_err_o    = err_q[0];
  assign m1_err_o    = err_q[1];
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter: vector table, per-requester scoreboards, bus target model.
`timescale 1ns/1ps
module tb_sys_bus_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata;
  logic [7:0]  m0_sel, m1_sel;
  logic        m0_wen, m0_ren, m1_wen, m1_ren;
  logic [63:0] m0_rdata_o, m1_rdata_o;
  logic        m0_err_o, m1_err_o, m0_ack_o, m1_ack_o;
  logic [31:0] sys_addr_o;
  logic [63:0] sys_wdata_o;
  logic [7:0]  sys_sel_o;
  logic        sys_wen_o, sys_ren_o;
  logic [63:0] sys_rdata;
  logic        sys_err, sys_ack;
  logic [1:0]  grant_o;
  logic        busy_o;

  always #5 clk = ~clk;

  sys_bus_arbiter #(.AW(32), .DW(64), .SW(8), .TIMEOUT(TIMEOUT)) dut (
    .axi_clk_i(clk), .axi_rst_i(rst),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_sel_i(m0_sel),
    .m0_wen_i(m0_wen), .m0_ren_i(m0_ren),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o), .m0_ack_o(m0_ack_o),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_sel_i(m1_sel),
    .m1_wen_i(m1_wen), .m1_ren_i(m1_ren),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o), .m1_ack_o(m1_ack_o),
    .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_sel_o(sys_sel_o),
    .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o),
    .sys_rdata_i(sys_rdata), .sys_err_i(sys_err), .sys_ack_i(sys_ack),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus target: acks on the second cycle of a strobe, with knobs for faults.
  logic [63:0] mem [0:8191];
  int  tgt_wait = 0;
  bit  tgt_noack = 0, tgt_err = 0, late_ack = 0, idle_ack = 0;

  always @(negedge clk) begin
    sys_ack   = 1'b0;
    sys_err   = 1'b0;
    sys_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    if (sys_wen_o || sys_ren_o) begin
      if (tgt_wait == 1 && !tgt_noack) begin
        sys_ack = 1'b1;
        sys_err = tgt_err;
        if (sys_wen_o) begin
          for (int b = 0; b < 8; b++)
            if (sys_sel_o[b]) mem[sys_addr_o[15:3]][b*8 +: 8] = sys_wdata_o[b*8 +: 8];
          sys_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        end else begin
          sys_rdata = mem[sys_addr_o[15:3]];
        end
      end
      tgt_wait++;
    end else begin
      tgt_wait = 0;
    end
    if (late_ack && (m0_ack_o || m1_ack_o)) begin
      sys_ack   = 1'b1;
      sys_rdata = 64'hFFFF_0000_FFFF_0000;
    end
    if (idle_ack) begin
      sys_ack   = 1'b1;
      sys_rdata = 64'h1234_1234_1234_1234;
    end
  end

  typedef struct {
    logic [63:0] rdata;
    bit          err;
  } sb_t;
  sb_t sb0[$];
  sb_t sb1[$];
  int  ack_log[$];

  // Monitor: every completion pulse pops the owning requester's scoreboard.
  always @(negedge clk) begin
    if (!rst && (m0_ack_o || m1_ack_o)) begin
      sb_t e;
      int  p;
      p = m1_ack_o ? 1 : 0;
      if (m0_ack_o && m1_ack_o) begin
        chk("dual_ack", {m1_ack_o, m0_ack_o}, 2'b01);
      end else if ((p == 0 && sb0.size() == 0) || (p == 1 && sb1.size() == 0)) begin
        chk("unexpected_ack", 64'(p + 1), 64'd0);
      end else begin
        e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
        ack_log.push_back(p);
        chk("ack_rdata", (p == 0) ? m0_rdata_o : m1_rdata_o, e.rdata);
        chk("ack_err", (p == 0) ? m0_err_o : m1_err_o, 64'(e.err));
        chk("ack_grant", grant_o, 64'(2'b01 << p));
        chk("ack_strobes_low", {sys_wen_o, sys_ren_o}, 2'b00);
        chk("ack_busy", busy_o, 1'b1);
      end
    end
  end

  task automatic drive(input int p, input bit wen, input bit ren, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    if (p == 0) begin
      m0_addr = a; m0_wdata = d; m0_sel = s; m0_wen = wen; m0_ren = ren;
    end else begin
      m1_addr = a; m1_wdata = d; m1_sel = s; m1_wen = wen; m1_ren = ren;
    end
  endtask

  // Called at a negedge; returns at the negedge of the idle cycle after completion.
  task automatic access(input int p, input bit wen, input bit ren, input logic [31:0] a,
                        input logic [63:0] d, input logic [7:0] s,
                        input logic [63:0] exp_rd, input bit exp_err, input int exp_lat);
    int  cyc;
    bit  got;
    sb_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    if (p == 0) sb0.push_back(e); else sb1.push_back(e);
    drive(p, wen, ren, a, d, s);
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (exp_lat > 0 && cyc == 1) begin
        chk("strobe_c1", {sys_wen_o, sys_ren_o}, {wen, ren & ~wen});
        chk("addr_c1", sys_addr_o, a);
        chk("grant_c1", grant_o, 64'(2'b01 << p));
      end
      got = (p == 0) ? m0_ack_o : m1_ack_o;
    end
    if (!got) chk("ack_wait_expired", 64'(cyc), 64'd0);
    else if (exp_lat > 0) chk("latency", 64'(cyc), 64'(exp_lat));
    drive(p, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
  endtask

  typedef struct {
    int          port;
    bit          wen;
    bit          ren;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  sel;
    logic [63:0] exp_rdata;
    bit          exp_err;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 1'b0, 1'b1, 32'h1000, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
    vecs[1] = '{1, 1'b1, 1'b0, 32'h2000, 64'hDEADBEEF12345678, 8'h0F, 64'h0, 1'b0};
    vecs[2] = '{0, 1'b0, 1'b1, 32'h2000, 64'h0, 8'h00, 64'h0000000012345678, 1'b0};
    vecs[3] = '{1, 1'b1, 1'b1, 32'h3000, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
    vecs[4] = '{1, 1'b0, 1'b1, 32'h3000, 64'h0, 8'h00, 64'h1122334455667788, 1'b0};
    vecs[5] = '{0, 1'b1, 1'b0, 32'h2000, 64'hAABBCCDD00000000, 8'hF0, 64'h0, 1'b0};
    vecs[6] = '{1, 1'b0, 1'b1, 32'h2000, 64'h0, 8'h00, 64'hAABBCCDD12345678, 1'b0};

    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem[13'h200] = 64'h0123456789ABCDEF;

    rst = 1'b1;
    drive(0, 1'b0, 1'b1, 32'h1000, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sys_bus", {sys_addr_o, sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o}, '0);
    chk("rst_m0", {m0_ack_o, m0_err_o, m0_rdata_o}, '0);
    chk("rst_m1", {m1_ack_o, m1_err_o, m1_rdata_o}, '0);
    chk("rst_grant_busy", {grant_o, busy_o}, '0);
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0, '0);

    // First tie after reset goes to m0.
    ack_log.delete();
    fork
      access(0, 1'b0, 1'b1, 32'h1000, '0, '0, 64'h0123456789ABCDEF, 1'b0, 0);
      access(1, 1'b0, 1'b1, 32'h1000, '0, '0, 64'h0123456789ABCDEF, 1'b0, 0);
    join
    chk("first_tie_m0", 64'(ack_log.size() > 0 ? ack_log[0] : 9), 64'd0);

    for (int i = 0; i < 7; i++)
      access(vecs[i].port, vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].wdata,
             vecs[i].sel, vecs[i].exp_rdata, vecs[i].exp_err, 3);

    // Continuous contention: m1 was served last, so m0 leads and grants alternate.
    ack_log.delete();
    fork
      for (int k = 0; k < 4; k++)
        access(0, 1'b0, 1'b1, 32'h1000, '0, '0, 64'h0123456789ABCDEF, 1'b0, 0);
      for (int k = 0; k < 4; k++)
        access(1, 1'b0, 1'b1, 32'h3000, '0, '0, 64'h1122334455667788, 1'b0, 0);
    join
    chk("contention_count", 64'(ack_log.size()), 64'd8);
    for (int k = 0; k < ack_log.size(); k++)
      chk("contention_order", 64'(ack_log[k]), 64'(k % 2));

    // Watchdog completion with a stale ack presented during RELEASE.
    tgt_noack = 1; late_ack = 1;
    access(1, 1'b0, 1'b1, 32'h3000, '0, '0, 64'h0, 1'b1, TIMEOUT + 1);
    tgt_noack = 0; late_ack = 0;
    chk("post_timeout_idle", {m1_ack_o, grant_o, busy_o}, '0);
    chk("timeout_err_hold", {m1_err_o, m1_rdata_o}, {1'b1, 64'h0});

    idle_ack = 1;
    @(negedge clk);
    idle_ack = 0;
    repeat (2) @(negedge clk);
    chk("idle_ack_ignored", {m0_ack_o, m1_ack_o, busy_o, grant_o, sys_wen_o, sys_ren_o}, '0);

    tgt_err = 1;
    access(0, 1'b0, 1'b1, 32'h1000, '0, '0, 64'h0123456789ABCDEF, 1'b1, 3);
    tgt_err = 0;
    chk("err_hold", m0_err_o, 1'b1);
    access(0, 1'b0, 1'b1, 32'h2000, '0, '0, 64'hAABBCCDD12345678, 1'b0, 3);

    // Reset in the middle of an access that would otherwise wait.
    tgt_noack = 1;
    drive(0, 1'b0, 1'b1, 32'h1000, '0, '0);
    repeat (3) @(negedge clk);
    chk("mid_busy", {busy_o, sys_ren_o}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outputs", {sys_wen_o, sys_ren_o, grant_o, busy_o, m0_ack_o, m0_err_o}, '0);
    chk("mid_rst_rdata", m0_rdata_o, 64'h0);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    tgt_noack = 0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_rst_no_ack", {m0_ack_o, m1_ack_o, busy_o}, '0);
    chk("scoreboard_drained", 64'(sb0.size() + sb1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
